// File: rtl/nes_bus_arb.sv
// nes_bus_arb: CPU-side arbiter between the 6502 core and the sprite-DMA master.
// It halts the core through RDY, lines the handoff up with the get/put cycle
// parity, and steers the shared CPU bus to whichever side owns it.
//
// Handshake: the DMA master raises i_spr_req and keeps it high for as long as
// it wants the bus; it may drive the bus only in cycles where o_spr_gnt = 1.
// Dropping i_spr_req (in any cycle, granted or not) ends the request, and the
// arbiter answers with one RELEASE turnaround cycle before the CPU runs again.
// o_spr_gnt can also fall without a handshake when i_rst is asserted.
module nes_bus_arb (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  output logic        o_cpu_rdy,
  input  logic        i_spr_req,
  output logic        o_spr_gnt,
  input  logic [15:0] i_spr_addr,
  input  logic        i_spr_wn,
  input  logic [7:0]  i_spr_wdata,
  output logic [15:0] o_bus_addr,
  output logic        o_bus_wn,
  output logic [7:0]  o_bus_wdata,
  output logic [9:0]  o_stall_cnt,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_GRANT   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [9:0] STALL_MAX = 10'd1023;

  state_t     state_q, state_d;
  logic       parity_q, parity_d;
  logic       rdy_q, rdy_d;
  logic       gnt_q, gnt_d;
  logic [9:0] stall_q, stall_d;

  // State register plus the registered outputs; reset wins over everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      gnt_q    <= 1'b0;
      stall_q  <= 10'd0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      rdy_q    <= rdy_d;
      gnt_q    <= gnt_d;
      stall_q  <= stall_d;
    end
  end

  // Next-state logic; a dropped request in HALT/ALIGN/GRANT always goes to RELEASE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (i_spr_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        // The core keeps running pending writes; a read cycle means it has stopped.
        if (!i_spr_req)    state_d = ST_RELEASE;
        else if (i_cpu_wn) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        // Leave only at the end of a parity-1 cycle so GRANT opens on parity 0.
        if (!i_spr_req)    state_d = ST_RELEASE;
        else if (parity_q) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (!i_spr_req) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered-output next values: RDY/GNT follow the next state so they line up with it.
  always_comb begin
    parity_d = ~parity_q;
    rdy_d    = (state_d == ST_IDLE);
    gnt_d    = (state_d == ST_GRANT);
    stall_d  = stall_q;
    if ((state_q == ST_IDLE) && (state_d == ST_HALT)) begin
      stall_d = 10'd0;
    end else if (!rdy_q && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 10'd1;
    end
  end

  // Bus mux from registered state; the master is routed only while its grant flop is set.
  always_comb begin
    o_bus_addr  = i_cpu_addr;
    o_bus_wn    = i_cpu_wn;
    o_bus_wdata = i_cpu_wdata;
    if (gnt_q) begin
      o_bus_addr  = i_spr_addr;
      o_bus_wn    = i_spr_wn;
      o_bus_wdata = i_spr_wdata;
    end else if (state_q == ST_ALIGN) begin
      // Dummy read at the CPU address while waiting for the right parity.
      o_bus_wn    = 1'b1;
      o_bus_wdata = 8'h00;
    end else if (state_q == ST_RELEASE) begin
      o_bus_wn    = 1'b1;
    end
  end

  assign o_cpu_rdy   = rdy_q;
  assign o_spr_gnt   = gnt_q;
  assign o_stall_cnt = stall_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_nes_bus_arb.sv
// tb_nes_bus_arb: scenario-driven bench for nes_bus_arb. Each DMA is modelled
// as a timeline (request cycle, halt exit, align end, grant window, release)
// computed from cycle numbers and parity, and every cycle's outputs are
// compared to the phase that timeline predicts.
module tb_nes_bus_arb;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_wn;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic        spr_req;
  logic        spr_gnt;
  logic [15:0] spr_addr;
  logic        spr_wn;
  logic [7:0]  spr_wdata;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic [9:0]  stall_cnt;
  logic [2:0]  dbg_state;

  nes_bus_arb dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wn    (cpu_wn),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdy   (cpu_rdy),
    .i_spr_req   (spr_req),
    .o_spr_gnt   (spr_gnt),
    .i_spr_addr  (spr_addr),
    .i_spr_wn    (spr_wn),
    .i_spr_wdata (spr_wdata),
    .o_bus_addr  (bus_addr),
    .o_bus_wn    (bus_wn),
    .o_bus_wdata (bus_wdata),
    .o_stall_cnt (stall_cnt),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;          // cycle index since last reset; parity of a cycle = cyc % 2
  int last_stall = 0;   // stall count the arbiter should be holding in IDLE
  logic [7:0] exp_q[$]; // CPU write data expected to reach the bus

  localparam int P_IDLE = 0, P_HALT = 1, P_ALIGN = 2, P_GRANT = 3, P_RELEASE = 4;

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_cpu_read();
    cpu_addr  = 16'($urandom);
    cpu_wn    = 1'b1;
    cpu_wdata = 8'($urandom);
  endtask

  task automatic drive_spr_random();
    spr_addr  = 16'($urandom);
    spr_wn    = 1'($urandom_range(0, 1));
    spr_wdata = 8'($urandom);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    spr_req = 1'b0;
    drive_cpu_read();
    drive_spr_random();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    last_stall = 0;
    cpu_wn = 1'b0;
    @(negedge clk);
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (spr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", spr_gnt); end
    checks++; if (stall_cnt !== 10'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++;
    if ({bus_addr, bus_wn, bus_wdata} !== {cpu_addr, cpu_wn, cpu_wdata}) begin
      errors++;
      $display("FAIL reset_bus got=%h/%b/%h exp=%h/%b/%h", bus_addr, bus_wn, bus_wdata, cpu_addr, cpu_wn, cpu_wdata);
    end
    next_cycle();
  endtask

  task automatic test_idle_traffic();
    for (int k = 0; k < 20; k++) begin
      spr_req   = 1'b0;
      cpu_addr  = 16'($urandom);
      cpu_wn    = 1'($urandom_range(0, 1));
      cpu_wdata = 8'($urandom);
      drive_spr_random();
      @(negedge clk);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL idle_rdy cyc=%0d got=%b exp=1", cyc, cpu_rdy); end
      checks++; if (spr_gnt !== 1'b0) begin errors++; $display("FAIL idle_gnt cyc=%0d got=%b exp=0", cyc, spr_gnt); end
      checks++; if (stall_cnt !== 10'(last_stall)) begin errors++; $display("FAIL idle_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, last_stall); end
      checks++;
      if ({bus_addr, bus_wn, bus_wdata} !== {cpu_addr, cpu_wn, cpu_wdata}) begin
        errors++;
        $display("FAIL idle_bus cyc=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, bus_addr, bus_wn, bus_wdata, cpu_addr, cpu_wn, cpu_wdata);
      end
      next_cycle();
    end
  endtask

  // One DMA request. req_par: parity of the cycle in which the request is
  // raised (-1 = raise now). w: CPU writes to $2003 right after the request.
  // len: grant cycles wanted. abort_off: >=0 drops the request in cycle
  // r+1+abort_off (before any grant). settle: add a checked IDLE cycle after.
  task automatic test_dma(input int req_par, input int w, input int len,
                          input int abort_off, input bit settle, output int final_stall);
    int r, h, a, g, rel, drop, ph, exp_stall, gnt_cnt, rdy_low;
    bit seen_gnt;
    logic [15:0] e_addr;
    logic        e_wn;
    logic [7:0]  e_wdata;
    logic [7:0]  got_w;
    final_stall = -1;
    gnt_cnt = 0;
    rdy_low = 0;
    seen_gnt = 1'b0;
    if (req_par >= 0) begin
      for (int k = 0; k < 2; k++) begin
        if ((cyc % 2) != req_par) begin
          spr_req = 1'b0;
          drive_cpu_read();
          drive_spr_random();
          next_cycle();
        end
      end
    end
    // Timeline from the arbiter's rules.
    r = cyc;
    h = r + w + 1;                     // first read cycle seen in HALT
    a = h + 1;                         // first ALIGN cycle
    g = a + (((a % 2) == 1) ? 1 : 2);  // grant opens on the next parity-0 cycle
    if (abort_off >= 0) begin
      drop = r + 1 + abort_off;
      rel  = drop + 1;
    end else begin
      drop = g + len - 1;
      rel  = g + len;
    end
    for (int t = r; t <= rel; t++) begin
      if (t == r)        ph = P_IDLE;
      else if (t == rel) ph = P_RELEASE;
      else if (t <= h)   ph = P_HALT;
      else if (t < g)    ph = P_ALIGN;
      else               ph = P_GRANT;
      spr_req = (t < drop);
      if ((t > r) && (t <= r + w) && (t < rel)) begin
        cpu_addr  = 16'h2003;
        cpu_wn    = 1'b0;
        cpu_wdata = 8'((t - r) * 17);
        exp_q.push_back(cpu_wdata);
      end else begin
        drive_cpu_read();
      end
      drive_spr_random();
      @(negedge clk);
      e_addr  = cpu_addr;
      e_wn    = cpu_wn;
      e_wdata = cpu_wdata;
      if (ph == P_ALIGN) begin
        e_wn = 1'b1;
        e_wdata = 8'h00;
      end else if (ph == P_RELEASE) begin
        e_wn = 1'b1;
      end else if (ph == P_GRANT) begin
        e_addr = spr_addr;
        e_wn = spr_wn;
        e_wdata = spr_wdata;
      end
      exp_stall = (t == r) ? last_stall : (((t - r - 1) > 1023) ? 1023 : (t - r - 1));
      checks++; if (cpu_rdy !== (ph == P_IDLE)) begin errors++; $display("FAIL dma_rdy cyc=%0d got=%b exp=%b", cyc, cpu_rdy, (ph == P_IDLE)); end
      checks++; if (spr_gnt !== (ph == P_GRANT)) begin errors++; $display("FAIL dma_gnt cyc=%0d got=%b exp=%b", cyc, spr_gnt, (ph == P_GRANT)); end
      checks++; if (stall_cnt !== 10'(exp_stall)) begin errors++; $display("FAIL dma_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, exp_stall); end
      checks++;
      if ({bus_addr, bus_wn, bus_wdata} !== {e_addr, e_wn, e_wdata}) begin
        errors++;
        $display("FAIL dma_bus cyc=%0d phase=%0d got=%h/%b/%h exp=%h/%b/%h", cyc, ph, bus_addr, bus_wn, bus_wdata, e_addr, e_wn, e_wdata);
      end
      // CPU writes issued during HALT must reach the bus in order.
      if ((bus_wn === 1'b0) && (ph != P_GRANT)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL dma_cpu_write cyc=%0d got=%h exp=none", cyc, bus_wdata);
        end else begin
          got_w = exp_q.pop_front();
          if ((bus_wdata !== got_w) || (bus_addr !== 16'h2003)) begin
            errors++;
            $display("FAIL dma_cpu_write cyc=%0d got=%h@%h exp=%h@2003", cyc, bus_wdata, bus_addr, got_w);
          end
        end
      end
      if (spr_gnt === 1'b1) begin
        if (!seen_gnt) begin
          seen_gnt = 1'b1;
          checks++;
          if ((cyc % 2) != 0) begin errors++; $display("FAIL grant_parity cyc=%0d got=1 exp=0", cyc); end
        end
        gnt_cnt++;
      end
      if (cpu_rdy === 1'b0) rdy_low++;
      next_cycle();
    end
    spr_req = 1'b0;
    last_stall = ((rel - r) > 1023) ? 1023 : (rel - r);
    checks++; if (gnt_cnt != ((abort_off >= 0) ? 0 : len)) begin errors++; $display("FAIL gnt_len got=%0d exp=%0d", gnt_cnt, (abort_off >= 0) ? 0 : len); end
    checks++; if (rdy_low != (rel - r)) begin errors++; $display("FAIL rdy_low_len got=%0d exp=%0d", rdy_low, rel - r); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cpu_writes_missing got=%0d exp=0", exp_q.size()); end
    exp_q.delete();
    if (settle) begin
      drive_cpu_read();
      drive_spr_random();
      @(negedge clk);
      checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL settle_rdy cyc=%0d got=%b exp=1", cyc, cpu_rdy); end
      checks++; if (stall_cnt !== 10'(last_stall)) begin errors++; $display("FAIL settle_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, last_stall); end
      final_stall = int'(stall_cnt);
      next_cycle();
    end
  endtask

  task automatic test_full_dma();
    int s;
    // Request raised in a parity-1 cycle: ALIGN is a single cycle.
    test_dma(1, 0, 512, -1, 1'b1, s);
    checks++; if (s != 515) begin errors++; $display("FAIL full_dma_short_align got=%0d exp=515", s); end
    // Request raised in a parity-0 cycle: ALIGN takes two cycles.
    test_dma(0, 0, 512, -1, 1'b1, s);
    checks++; if (s != 516) begin errors++; $display("FAIL full_dma_long_align got=%0d exp=516", s); end
  endtask

  task automatic test_cpu_writes();
    int s;
    test_dma(-1, 3, 8, -1, 1'b1, s);
  endtask

  task automatic test_abort();
    int s;
    test_dma(-1, 0, 5, 1, 1'b1, s);   // drop in the first ALIGN cycle
    test_dma(-1, 2, 5, 1, 1'b1, s);   // drop in HALT while writes are draining
  endtask

  task automatic test_back_to_back();
    int s;
    test_dma(-1, $urandom_range(0, 3), $urandom_range(1, 20), -1, 1'b0, s);
    test_dma(-1, $urandom_range(0, 3), $urandom_range(1, 20), -1, 1'b1, s);
  endtask

  task automatic test_random();
    int s, w, ab;
    for (int k = 0; k < 6; k++) begin
      w  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w + 1) : -1;
      test_dma($urandom_range(0, 2) - 1, w, $urandom_range(1, 40), ab, 1'($urandom_range(0, 1)), s);
    end
    test_dma(-1, 0, 1, -1, 1'b1, s);
  endtask

  task automatic test_saturation();
    int s;
    test_dma(-1, 0, 1100, -1, 1'b1, s);
    checks++; if (s != 1023) begin errors++; $display("FAIL stall_saturate got=%0d exp=1023", s); end
  endtask

  task automatic test_reset_mid_grant();
    bit got;
    got = 1'b0;
    spr_req = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      drive_cpu_read();
      drive_spr_random();
      @(negedge clk);
      if (spr_gnt === 1'b1) got = 1'b1;
      next_cycle();
    end
    checks++; if (!got) begin errors++; $display("FAIL rst_grant_wait got=0 exp=1"); end
    // Byte 100 of the transfer: two master cycles per byte.
    for (int k = 0; k < 199; k++) begin
      drive_cpu_read();
      drive_spr_random();
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    spr_req = 1'b0;
    cyc = 0;
    last_stall = 0;
    drive_cpu_read();
    drive_spr_random();
    @(negedge clk);
    checks++; if (spr_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt got=%b exp=0", spr_gnt); end
    checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got=%b exp=1", cpu_rdy); end
    checks++; if (stall_cnt !== 10'd0) begin errors++; $display("FAIL rst_mid_stall got=%0d exp=0", stall_cnt); end
    checks++;
    if ({bus_addr, bus_wn, bus_wdata} !== {cpu_addr, cpu_wn, cpu_wdata}) begin
      errors++;
      $display("FAIL rst_mid_bus got=%h/%b/%h exp=%h/%b/%h", bus_addr, bus_wn, bus_wdata, cpu_addr, cpu_wn, cpu_wdata);
    end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_idle_traffic();
    test_full_dma();
    test_cpu_writes();
    test_abort();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid_grant();
    test_dma(0, 1, 16, -1, 1'b1, last_stall);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog cyc=%0d exp=finish", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
